// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - parity select encodings (line parity_type input)
//   - baud select codes and baud_div() clocks-per-bit helper
//   - transmitter FSM state type
package uart_pkg;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;

   localparam logic [1:0] BAUD_2400  = 2'b00;
   localparam logic [1:0] BAUD_4800  = 2'b01;
   localparam logic [1:0] BAUD_9600  = 2'b10;
   localparam logic [1:0] BAUD_19200 = 2'b11;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   // Clocks per bit for a baud select code, truncated.
   function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [1:0] sel);
      int unsigned baud;
      case (sel)
         BAUD_2400: baud = 2400;
         BAUD_4800: baud = 4800;
         BAUD_9600: baud = 9600;
         default:   baud = 19200;
      endcase
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write/status bundle of uart_tx_fifo.
//   wr_en, wr_data, clr_ovf          host -> transmitter (master drives)
//   fifo_full, fifo_empty,
//   fifo_level, overflow_flag        transmitter -> host (slave drives)
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 clr_ovf;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [LVL_W-1:0]     fifo_level;
   logic                 overflow_flag;

   modport master (
      output wr_en, wr_data, clr_ovf,
      input  fifo_full, fifo_empty, fifo_level, overflow_flag
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf,
      output fifo_full, fifo_empty, fifo_level, overflow_flag
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with exact occupancy count.
//   clock, reset_n   clock / synchronous active-low reset
//   wr_en, wr_data   push request and payload (dropped while full)
//   rd_en, rd_data   pop request; rd_data always shows the head entry
//   full, empty      occupancy status
//   level            entry count, 0..DEPTH
//   ovf_pulse        high in any cycle a push is attempted while full
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf_pulse
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_wr, do_rd;

   // Fullness is judged on the registered count, so a push that coincides
   // with a pop while full is still dropped.
   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign rd_data   = mem_q[rd_ptr_q];
   assign do_wr     = wr_en & ~full;
   assign do_rd     = rd_en & ~empty;
   assign ovf_pulse = wr_en & full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset: a zero count makes stale entries unreachable.
   always_ff @(posedge clock) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, LSB first, optional parity,
// one or two stop bits, frames sent back-to-back from a TX FIFO.
//   clock, reset_n     clock / synchronous active-low reset
//   host (slave)       wr_en/wr_data/clr_ovf in; fifo_full/fifo_empty/
//                      fifo_level/overflow_flag out
//   parity_type        00 none, 01 odd, 10 even, 11 none (latched per frame)
//   baud_rate          00 2400, 01 4800, 10 9600, 11 19200 (latched per frame)
//   stop_bits          0 one stop bit, 1 two (latched per frame)
//   data_tx            serial line, idles high
//   tx_active_flag     high while a frame is on the line
//   tx_done_flag       one-clock pulse on the last clock of each frame
//   send_break         only with UART_TX_BREAK_EN defined: holds the line low
//                      while idle and suppresses FIFO pops
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int          DATA_BITS  = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter int          DIV_W      = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   uart_tx_fifo_if.slave        host,
   input  logic [1:0]           parity_type,
   input  logic [1:0]           baud_rate,
   input  logic                 stop_bits,
   output logic                 data_tx,
   output logic                 tx_active_flag,
   output logic                 tx_done_flag
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                 send_break
`endif
);

   localparam int BIT_W = 4;

   localparam logic [DIV_W-1:0] LAST_2400  = DIV_W'(baud_div(CLK_FREQ, BAUD_2400) - 1);
   localparam logic [DIV_W-1:0] LAST_4800  = DIV_W'(baud_div(CLK_FREQ, BAUD_4800) - 1);
   localparam logic [DIV_W-1:0] LAST_9600  = DIV_W'(baud_div(CLK_FREQ, BAUD_9600) - 1);
   localparam logic [DIV_W-1:0] LAST_19200 = DIV_W'(baud_div(CLK_FREQ, BAUD_19200) - 1);

   tx_state_t            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [1:0]           ptype_q, ptype_d;
   logic [1:0]           baud_q, baud_d;
   logic                 stop2_q, stop2_d;
   logic                 tx_q, tx_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;

   logic                 pop;
   logic                 brk;
   logic                 bit_end;
   logic                 ovf_pulse;
   logic [DIV_W-1:0]     div_last;
   logic [DATA_BITS-1:0] head;

`ifdef UART_TX_BREAK_EN
   assign brk = send_break;
`else
   assign brk = 1'b0;
`endif

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en     (host.wr_en),
      .wr_data   (host.wr_data),
      .rd_en     (pop),
      .rd_data   (head),
      .full      (host.fifo_full),
      .empty     (host.fifo_empty),
      .level     (host.fifo_level),
      .ovf_pulse (ovf_pulse)
   );

   always_comb begin
      case (baud_q)
         BAUD_2400: div_last = LAST_2400;
         BAUD_4800: div_last = LAST_4800;
         BAUD_9600: div_last = LAST_9600;
         default:   div_last = LAST_19200;
      endcase
   end

   assign bit_end = (div_q == div_last);

   // Line outputs are registered from the current state, so the line trails
   // the FSM by one clock: a pop at edge N+1 shows as a start bit at N+2.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      ptype_d  = ptype_q;
      baud_d   = baud_q;
      stop2_d  = stop2_q;
      tx_d     = 1'b1;
      done_d   = 1'b0;
      active_d = (state_q != IDLE);
      pop      = 1'b0;

      if (state_q != IDLE) div_d = bit_end ? '0 : div_q + DIV_W'(1);

      case (state_q)
         IDLE: begin
            div_d = '0;
            bit_d = '0;
            if (brk) begin
               tx_d = 1'b0;
            end else if (!host.fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = (parity_type == PAR_ODD) ? ~^head : ^head;
               ptype_d = parity_type;
               baud_d  = baud_rate;
               stop2_d = stop_bits;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            tx_d = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (ptype_q == PAR_ODD || ptype_q == PAR_EVEN) ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            tx_d = par_q;
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (bit_q == BIT_W'(stop2_q)) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A new overflow in the same cycle as clr_ovf keeps the flag set.
   assign ovf_d = (ovf_q & ~host.clr_ovf) | ovf_pulse;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         ptype_q  <= '0;
         baud_q   <= '0;
         stop2_q  <= 1'b0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         ptype_q  <= ptype_d;
         baud_q   <= baud_d;
         stop2_q  <= stop2_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign data_tx            = tx_q;
   assign tx_active_flag     = active_q;
   assign tx_done_flag       = done_q;
   assign host.overflow_flag = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// CLK_FREQ is lowered to 96 kHz so bit periods are short:
// 2400 -> 40, 4800 -> 20, 9600 -> 10, 19200 -> 5 clocks per bit.
// Build with UART_TX_BREAK_EN defined to include the break checks.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_FREQ   = 96_000;
   localparam int          DATA_BITS  = 8;
   localparam int          FIFO_DEPTH = 16;
   localparam int          DIV_W      = 16;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] parity_type;
   logic [1:0] baud_rate;
   logic       stop_bits;
   logic       data_tx;
   logic       tx_active_flag;
   logic       tx_done_flag;
`ifdef UART_TX_BREAK_EN
   logic       send_break;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int done_cnt = 0;

   always #5 clock = ~clock;

   uart_tx_fifo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) host ();

   uart_tx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .DATA_BITS  (DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .host           (host),
      .parity_type    (parity_type),
      .baud_rate      (baud_rate),
      .stop_bits      (stop_bits),
      .data_tx        (data_tx),
      .tx_active_flag (tx_active_flag),
      .tx_done_flag   (tx_done_flag)
`ifdef UART_TX_BREAK_EN
      ,
      .send_break     (send_break)
`endif
   );

   always @(posedge clock) if (tx_done_flag === 1'b1) done_cnt++;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic push(input logic [7:0] v);
      host.wr_en   = 1'b1;
      host.wr_data = v;
      tick();
      host.wr_en   = 1'b0;
   endtask

   task automatic wait_fall(input string tag, input int limit, output int at);
      int k = 0;
      while (data_tx !== 1'b0 && k < limit) begin
         tick();
         k++;
      end
      at = cyc;
      check_eq({tag, "_start"}, int'(data_tx), 0);
   endtask

   // Waits for the one-clock idle gap between frames.
   task automatic wait_gap(input string tag, input int limit);
      int k = 0;
      while (tx_active_flag !== 1'b0 && k < limit) begin
         tick();
         k++;
      end
      check_eq({tag, "_gap"}, int'(tx_active_flag), 0);
   endtask

   // Called on the first sample of a start bit; samples each bit mid-period.
   task automatic sample_frame(input int d, input int nbits, output int bits);
      bits = 0;
      tick(d / 2);
      bits[0] = data_tx;
      for (int i = 1; i < nbits; i++) begin
         tick(d);
         bits[i] = data_tx;
      end
   endtask

   initial begin
      int t0, t1, t2, bits, d0, lows, v;

      reset_n      = 1'b0;
      parity_type  = 2'b00;
      baud_rate    = 2'b00;
      stop_bits    = 1'b0;
      host.wr_en   = 1'b0;
      host.wr_data = '0;
      host.clr_ovf = 1'b0;
`ifdef UART_TX_BREAK_EN
      send_break   = 1'b0;
`endif

      // Reset state
      tick(2);
      check_eq("rst_tx",     int'(data_tx), 1);
      check_eq("rst_active", int'(tx_active_flag), 0);
      check_eq("rst_done",   int'(tx_done_flag), 0);
      check_eq("rst_ovf",    int'(host.overflow_flag), 0);
      check_eq("rst_empty",  int'(host.fifo_empty), 1);
      check_eq("rst_full",   int'(host.fifo_full), 0);
      check_eq("rst_level",  int'(host.fifo_level), 0);
      reset_n = 1'b1;
      tick(3);

      // 8'hCA, 9600, odd parity, 1 stop; config changed mid-frame has no effect
      parity_type = 2'b01;
      baud_rate   = 2'b10;
      stop_bits   = 1'b0;
      d0 = done_cnt;
      push(8'hCA);
      check_eq("lat_lvl_n",  int'(host.fifo_level), 1);
      check_eq("lat_tx_n",   int'(data_tx), 1);
      tick();
      check_eq("lat_lvl_n1", int'(host.fifo_level), 0);
      check_eq("lat_tx_n1",  int'(data_tx), 1);
      tick();
      check_eq("lat_tx_n2",  int'(data_tx), 0);
      check_eq("lat_act_n2", int'(tx_active_flag), 1);
      parity_type = 2'b00;
      baud_rate   = 2'b00;
      stop_bits   = 1'b1;
      sample_frame(10, 11, bits);
      check_eq("ca_bits", bits, 'h794);
      tick(20);
      check_eq("ca_done",   done_cnt - d0, 1);
      check_eq("ca_active", int'(tx_active_flag), 0);
      check_eq("ca_idle",   int'(data_tx), 1);

      // Back-to-back 8'hAA, 8'h55, 8'h0F at 19200, even parity, 2 stop
      parity_type = 2'b10;
      baud_rate   = 2'b11;
      stop_bits   = 1'b1;
      d0 = done_cnt;
      push(8'hAA);
      push(8'h55);
      push(8'h0F);
      check_eq("b2b_lvl0", int'(host.fifo_level), 2);
      wait_fall("b2b_f0", 10, t0);
      sample_frame(5, 12, bits);
      check_eq("b2b_aa", bits, 'hD54);
      wait_fall("b2b_f1", 40, t1);
      check_eq("b2b_gap1", t1 - t0, 61);
      check_eq("b2b_lvl1", int'(host.fifo_level), 1);
      sample_frame(5, 12, bits);
      check_eq("b2b_55", bits, 'hCAA);
      wait_fall("b2b_f2", 40, t2);
      check_eq("b2b_gap2", t2 - t1, 61);
      check_eq("b2b_lvl2", int'(host.fifo_level), 0);
      sample_frame(5, 12, bits);
      check_eq("b2b_0f", bits, 'hC1E);
      tick(15);
      check_eq("b2b_done", done_cnt - d0, 3);

      // Overflow: first entry pops at once, so 18 writes fill 16 and drop one
      parity_type = 2'b00;
      baud_rate   = 2'b11;
      stop_bits   = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 18; i++) push(8'(8'h30 + i));
      check_eq("ovf_full",  int'(host.fifo_full), 1);
      check_eq("ovf_flag",  int'(host.overflow_flag), 1);
      check_eq("ovf_level", int'(host.fifo_level), 16);
      host.clr_ovf = 1'b1;
      host.wr_en   = 1'b1;
      host.wr_data = 8'hEE;
      tick();
      host.clr_ovf = 1'b0;
      host.wr_en   = 1'b0;
      check_eq("ovf_setwins", int'(host.overflow_flag), 1);
      check_eq("ovf_lvl_kept", int'(host.fifo_level), 16);
      host.clr_ovf = 1'b1;
      tick();
      host.clr_ovf = 1'b0;
      check_eq("ovf_clr", int'(host.overflow_flag), 0);
      for (int k = 1; k <= 16; k++) begin
         wait_gap("ovf_frm", 200);
         wait_fall("ovf_frm", 10, t0);
         sample_frame(5, 10, bits);
         v = 'h30 + k;
         check_eq($sformatf("ovf_frame%0d", k), bits, 'h200 | (v << 1));
      end
      tick(10);
      check_eq("ovf_frames", done_cnt - d0, 17);
      check_eq("ovf_empty",  int'(host.fifo_empty), 1);
      check_eq("ovf_nfull",  int'(host.fifo_full), 0);

      // Reset during DATA bit 3 with one entry still queued
      baud_rate = 2'b10;
      push(8'hC3);
      push(8'h3C);
      wait_fall("mid", 10, t0);
      d0 = done_cnt;
      tick(45);
      check_eq("mid_lvl_pre", int'(host.fifo_level), 1);
      reset_n = 1'b0;
      tick();
      check_eq("mid_tx",     int'(data_tx), 1);
      check_eq("mid_level",  int'(host.fifo_level), 0);
      check_eq("mid_active", int'(tx_active_flag), 0);
      reset_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (data_tx !== 1'b1) lows++;
      end
      check_eq("mid_quiet", lows, 0);
      check_eq("mid_nodone", done_cnt - d0, 0);

`ifdef UART_TX_BREAK_EN
      // Break holds the line low and blocks pops until released
      baud_rate  = 2'b11;
      send_break = 1'b1;
      tick(2);
      push(8'h5A);
      push(8'hA5);
      tick(3);
      check_eq("brk_level", int'(host.fifo_level), 2);
      check_eq("brk_tx",    int'(data_tx), 0);
      send_break = 1'b0;
      lows = 0;
      while (data_tx !== 1'b1 && lows < 10) begin
         tick();
         lows++;
      end
      wait_fall("brk_f0", 10, t0);
      sample_frame(5, 10, bits);
      check_eq("brk_5a", bits, 'h200 | ('h5A << 1));
      wait_gap("brk_f1", 100);
      wait_fall("brk_f1", 10, t1);
      sample_frame(5, 10, bits);
      check_eq("brk_a5", bits, 'h200 | ('hA5 << 1));
      check_eq("brk_empty", int'(host.fifo_level), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
